// File: rtl/pwm_multi_pkg.sv
// rtl/pwm_multi_pkg.sv - shared types, register map and CTRL bit layout for pwm_multi
package pwm_multi_pkg;

  localparam logic [1:0] REG_COUNT = 2'd0;
  localparam logic [1:0] REG_ON    = 2'd1;
  localparam logic [1:0] REG_OFF   = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  localparam int CTRL_LEVEL      = 0;
  localparam int CTRL_RUNNING    = 1;
  localparam int CTRL_ONE_SHOT   = 2;
  localparam int CTRL_POS_IRQ_EN = 3;
  localparam int CTRL_NEG_IRQ_EN = 4;
  localparam int CTRL_POS_FLAG   = 5;
  localparam int CTRL_NEG_FLAG   = 6;
  localparam int CTRL_INVERT     = 7;

  localparam logic [7:0] CTRL_RO_MASK  = 8'(1 << CTRL_LEVEL);
  localparam logic [7:0] CTRL_W1C_MASK = 8'((1 << CTRL_POS_FLAG) | (1 << CTRL_NEG_FLAG));
  localparam logic [7:0] CTRL_RW_MASK  = 8'((1 << CTRL_RUNNING) | (1 << CTRL_ONE_SHOT) |
                                            (1 << CTRL_POS_IRQ_EN) | (1 << CTRL_NEG_IRQ_EN) |
                                            (1 << CTRL_INVERT));

  typedef struct packed {
    logic invert;
    logic neg_flag;
    logic pos_flag;
    logic neg_irq_en;
    logic pos_irq_en;
    logic one_shot;
    logic running;
    logic level;
  } ctrl_t;

  function automatic logic ctrl_irq(input ctrl_t c);
    return (c.pos_flag & c.pos_irq_en) | (c.neg_flag & c.neg_irq_en);
  endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// rtl/pwm_multi_if.sv - Avalon-MM register slave bundle for pwm_multi
interface pwm_multi_if #(
  parameter int NUM_CHANNELS = 4
);
  localparam int ADDR_W = $clog2(NUM_CHANNELS) + 2;

  logic [ADDR_W-1:0] avs_s0_address;
  logic              avs_s0_read;
  logic              avs_s0_write;
  logic [31:0]       avs_s0_writedata;
  logic [31:0]       avs_s0_readdata;

  modport master (
    output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    input  avs_s0_readdata
  );

  modport slave (
    input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    output avs_s0_readdata
  );
endinterface

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: down-counter, double-buffered on/off times, CTRL state
module pwm_channel
  import pwm_multi_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [1:0]  reg_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        out_o,
  output logic        irq_o
);

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] on_act_q, on_act_d;
  logic [COUNTER_WIDTH-1:0] off_act_q, off_act_d;
  logic [COUNTER_WIDTH-1:0] on_sh_q, on_sh_d;
  logic [COUNTER_WIDTH-1:0] off_sh_q, off_sh_d;
  ctrl_t                    ctrl_q, ctrl_d;

  logic [COUNTER_WIDTH-1:0] wval;
  logic [7:0]               wbyte;
  logic                     ctrl_wr;
  logic                     start;
  logic                     stop;
  logic                     pos_set;
  logic                     neg_set;
  logic                     unused_wdata;

  assign wval         = wdata_i[COUNTER_WIDTH-1:0];
  assign wbyte        = wdata_i[7:0];
  assign unused_wdata = ^wdata_i;
  assign ctrl_wr      = wr_en_i && (reg_i == REG_CTRL);
  assign start        = ctrl_wr && wbyte[CTRL_RUNNING] && !ctrl_q.running;
  assign stop         = ctrl_wr && !wbyte[CTRL_RUNNING] && ctrl_q.running;

  always_comb begin
    cnt_d     = cnt_q;
    on_act_d  = on_act_q;
    off_act_d = off_act_q;
    on_sh_d   = on_sh_q;
    off_sh_d  = off_sh_q;
    ctrl_d    = ctrl_q;
    pos_set   = 1'b0;
    neg_set   = 1'b0;

    if (ctrl_wr) begin
      ctrl_d = ctrl_t'((ctrl_q & ~CTRL_RW_MASK & ~(wbyte & CTRL_W1C_MASK)) |
                       (wbyte & CTRL_RW_MASK));
    end

    // Stop wins over any hardware boundary on the same edge; counter is frozen.
    if (start) begin
      on_act_d     = on_sh_q;
      off_act_d    = off_sh_q;
      cnt_d        = on_sh_q;
      ctrl_d.level = 1'b1;
      pos_set      = 1'b1;
    end else if (stop) begin
      ctrl_d.level = 1'b0;
    end else if (ctrl_q.running) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - COUNTER_WIDTH'(1);
      end else if (ctrl_q.level) begin
        ctrl_d.level = 1'b0;
        neg_set      = 1'b1;
        if (ctrl_q.one_shot) begin
          ctrl_d.running = 1'b0;
        end else begin
          cnt_d = off_act_q;
        end
      end else begin
        on_act_d     = on_sh_q;
        off_act_d    = off_sh_q;
        cnt_d        = on_sh_q;
        ctrl_d.level = 1'b1;
        pos_set      = 1'b1;
      end
    end else begin
      on_act_d  = on_sh_q;
      off_act_d = off_sh_q;
    end

    if (pos_set) ctrl_d.pos_flag = 1'b1;
    if (neg_set) ctrl_d.neg_flag = 1'b1;

    if (wr_en_i && reg_i == REG_ON)    on_sh_d  = wval;
    if (wr_en_i && reg_i == REG_OFF)   off_sh_d = wval;
    if (wr_en_i && reg_i == REG_COUNT) cnt_d    = wval;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      on_act_q  <= '0;
      off_act_q <= '0;
      on_sh_q   <= '0;
      off_sh_q  <= '0;
      ctrl_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      on_act_q  <= on_act_d;
      off_act_q <= off_act_d;
      on_sh_q   <= on_sh_d;
      off_sh_q  <= off_sh_d;
      ctrl_q    <= ctrl_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (reg_i)
      REG_COUNT: rdata_o = 32'(cnt_q);
      REG_ON:    rdata_o = 32'(on_sh_q);
      REG_OFF:   rdata_o = 32'(off_sh_q);
      REG_CTRL:  rdata_o = {24'd0, ctrl_q};
      default:   rdata_o = '0;
    endcase
  end

  assign out_o = ctrl_q.level ^ ctrl_q.invert;
  assign irq_o = ctrl_irq(ctrl_q);

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - N-channel PWM generator with Avalon-MM registers and combined interrupt
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                    csi_clk,
  input  logic                    rsi_reset,
  pwm_multi_if.slave              s0,
  output logic                    ins_irq_n,
  output logic [NUM_CHANNELS-1:0] coe_conduit_output
);

  localparam int ADDR_W = $clog2(NUM_CHANNELS) + 2;
  localparam int IDX_W  = (ADDR_W > 2) ? ADDR_W - 2 : 1;

  logic [IDX_W-1:0]        ch_idx;
  logic [1:0]              reg_sel;
  logic [NUM_CHANNELS-1:0] wr_en;
  logic [NUM_CHANNELS-1:0] irq_vec;
  logic [31:0]             rdata [NUM_CHANNELS];
  logic [31:0]             rd_mux;
  logic [31:0]             readdata_q;

  assign reg_sel = s0.avs_s0_address[1:0];

  generate
    if (ADDR_W > 2) begin : g_idx
      assign ch_idx = s0.avs_s0_address[ADDR_W-1:2];
    end else begin : g_idx_single
      assign ch_idx = '0;
    end
  endgenerate

  // Channel indices with no matching instance select nothing: reads 0, writes dropped.
  always_comb begin
    wr_en  = '0;
    rd_mux = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (ch_idx == IDX_W'(i)) begin
        wr_en[i] = s0.avs_s0_write;
        rd_mux   = rdata[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      pwm_channel #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
      ) u_ch (
        .clk_i   (csi_clk),
        .rst_i   (rsi_reset),
        .wr_en_i (wr_en[g]),
        .reg_i   (reg_sel),
        .wdata_i (s0.avs_s0_writedata),
        .rdata_o (rdata[g]),
        .out_o   (coe_conduit_output[g]),
        .irq_o   (irq_vec[g])
      );
    end
  endgenerate

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      readdata_q <= '0;
    end else if (s0.avs_s0_read) begin
      readdata_q <= rd_mux;
    end
  end

  assign s0.avs_s0_readdata = readdata_q;
  assign ins_irq_n          = ~|irq_vec;

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - self-checking bench for pwm_multi (4ch/32-bit and 3ch/8-bit builds)
module tb_pwm_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       irq_n, irq2_n;
  logic [3:0] pwm;
  logic [2:0] pwm2;

  pwm_multi_if #(.NUM_CHANNELS(4)) bus ();
  pwm_multi_if #(.NUM_CHANNELS(3)) bus2 ();

  pwm_multi #(.NUM_CHANNELS(4), .COUNTER_WIDTH(32)) dut (
    .csi_clk(clk), .rsi_reset(rst), .s0(bus), .ins_irq_n(irq_n), .coe_conduit_output(pwm)
  );

  pwm_multi #(.NUM_CHANNELS(3), .COUNTER_WIDTH(8)) dut2 (
    .csi_clk(clk), .rsi_reset(rst), .s0(bus2), .ins_irq_n(irq2_n), .coe_conduit_output(pwm2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cap_q[$];
  bit exp_q[$];

  // All bus tasks are entered on a negedge and return on the negedge after the effective edge.
  task automatic bus_write(input int ch, input int r, input logic [31:0] d);
    bus.avs_s0_address   = 4'(ch * 4 + r);
    bus.avs_s0_writedata = d;
    bus.avs_s0_write     = 1'b1;
    @(negedge clk);
    bus.avs_s0_write     = 1'b0;
  endtask

  task automatic bus_read(input int ch, input int r, output logic [31:0] d);
    bus.avs_s0_address = 4'(ch * 4 + r);
    bus.avs_s0_read    = 1'b1;
    @(negedge clk);
    bus.avs_s0_read    = 1'b0;
    d = bus.avs_s0_readdata;
  endtask

  task automatic b2_write(input int ch, input int r, input logic [31:0] d);
    bus2.avs_s0_address   = 4'(ch * 4 + r);
    bus2.avs_s0_writedata = d;
    bus2.avs_s0_write     = 1'b1;
    @(negedge clk);
    bus2.avs_s0_write     = 1'b0;
  endtask

  task automatic b2_read(input int ch, input int r, output logic [31:0] d);
    bus2.avs_s0_address = 4'(ch * 4 + r);
    bus2.avs_s0_read    = 1'b1;
    @(negedge clk);
    bus2.avs_s0_read    = 1'b0;
    d = bus2.avs_s0_readdata;
  endtask

  task automatic capture(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      cap_q.push_back(pwm[ch]);
      @(negedge clk);
    end
  endtask

  // Reference waveform: ON lasts on+1 cycles, OFF lasts off+1 cycles, starting with ON.
  function automatic void model_periodic(input int on, input int off, input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back((k % (on + off + 2)) < (on + 1));
  endfunction

  function automatic void model_phase(input bit lvl, input int len);
    for (int k = 0; k < len; k++) exp_q.push_back(lvl);
  endfunction

  function automatic int count_diff();
    int e = 0;
    if (cap_q.size() != exp_q.size()) return 999;
    foreach (cap_q[k]) if (cap_q[k] != exp_q[k]) e++;
    return e;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    n_checks++;
    if ({pwm, irq_n, bus.avs_s0_readdata} !== {4'b0, 1'b1, 32'b0})
      $display("FAIL reset_outputs: got pwm=%0h irq_n=%0b rd=%0h, expected 0/1/0", pwm, irq_n, bus.avs_s0_readdata);
    else n_pass++;
    bus_write(1, 1, 32'd9);
    bus_write(0, 1, 32'd3);
    bus_write(0, 2, 32'd5);
    bus_write(0, 3, 32'h0A);
    n_checks++;
    if (irq_n !== 1'b0) $display("FAIL pre_reset_irq: got %0b expected 0", irq_n);
    else n_pass++;
    bus_read(1, 1, d);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (pwm !== 4'b0) $display("FAIL midrun_reset_pwm: got %0h expected 0", pwm);
    else n_pass++;
    n_checks++;
    if (irq_n !== 1'b1) $display("FAIL midrun_reset_irq: got %0b expected 1", irq_n);
    else n_pass++;
    n_checks++;
    if (bus.avs_s0_readdata !== 32'b0) $display("FAIL midrun_reset_rdata: got %0h expected 0", bus.avs_s0_readdata);
    else n_pass++;
    for (int a = 0; a < 16; a++) begin
      bus_read(a / 4, a % 4, d);
      n_checks++;
      if (d !== 32'b0) $display("FAIL reset_reg_%0d: got %0h expected 0", a, d);
      else n_pass++;
    end
  endtask

  task automatic test_period();
    logic [31:0] d;
    int on, off, n, e;
    for (int it = 0; it < 4; it++) begin
      on  = (it == 0) ? 3 : int'($urandom_range(0, 9));
      off = (it == 0) ? 5 : int'($urandom_range(0, 9));
      n   = 2 * (on + off + 2) + 3;
      bus_write(0, 1, 32'(on));
      bus_write(0, 2, 32'(off));
      bus_write(0, 3, 32'h02);
      cap_q.delete();
      capture(0, n);
      model_periodic(on, off, n);
      e = count_diff();
      n_checks++;
      if (e !== 0) $display("FAIL period_wave on=%0d off=%0d: got %0d differing samples expected 0", on, off, e);
      else n_pass++;
      bus_read(0, 3, d);
      n_checks++;
      if ((d & 32'hFE) !== 32'h62) $display("FAIL period_ctrl on=%0d off=%0d: got %0h expected 62", on, off, d & 32'hFE);
      else n_pass++;
      bus_write(0, 3, 32'h60);
      bus_read(0, 3, d);
      n_checks++;
      if (d !== 32'h0) $display("FAIL period_stop_ctrl: got %0h expected 0", d);
      else n_pass++;
    end
  endtask

  task automatic test_stop_and_count();
    logic [31:0] d;
    int e;
    bus_write(0, 1, 32'd20);
    bus_write(0, 2, 32'd3);
    bus_write(0, 3, 32'h02);
    cap_q.delete();
    cap_q.push_back(pwm[0]);
    bus_write(0, 0, 32'd2);
    capture(0, 9);
    exp_q.delete();
    model_phase(1'b1, 4);
    model_phase(1'b0, 4);
    model_phase(1'b1, 2);
    e = count_diff();
    n_checks++;
    if (e !== 0) $display("FAIL count_write_wave: got %0d differing samples expected 0", e);
    else n_pass++;
    // Reload happened 3 edges before the stop edge, so two decrements have occurred.
    bus_write(0, 3, 32'h00);
    n_checks++;
    if (pwm[0] !== 1'b0) $display("FAIL stop_level: got %0b expected 0", pwm[0]);
    else n_pass++;
    bus_read(0, 0, d);
    n_checks++;
    if (d !== 32'd18) $display("FAIL stop_count_hold: got %0d expected 18", d);
    else n_pass++;
    bus_write(0, 0, 32'h1234);
    bus_read(0, 0, d);
    n_checks++;
    if (d !== 32'h1234) $display("FAIL stopped_count_write: got %0h expected 1234", d);
    else n_pass++;
  endtask

  task automatic test_shadow_update();
    logic [31:0] d;
    int e;
    bus_write(1, 1, 32'd3);
    bus_write(1, 2, 32'd5);
    bus_write(1, 3, 32'h02);
    cap_q.delete();
    cap_q.push_back(pwm[1]);
    bus_write(1, 1, 32'd7);
    capture(1, 23);
    exp_q.delete();
    model_phase(1'b1, 4);
    model_phase(1'b0, 6);
    model_phase(1'b1, 8);
    model_phase(1'b0, 6);
    e = count_diff();
    n_checks++;
    if (e !== 0) $display("FAIL shadow_wave: got %0d differing samples expected 0", e);
    else n_pass++;
    bus_read(1, 1, d);
    n_checks++;
    if (d !== 32'd7) $display("FAIL shadow_readback: got %0d expected 7", d);
    else n_pass++;
    bus_write(1, 3, 32'h60);
  endtask

  task automatic test_one_shot();
    logic [31:0] d;
    int e;
    bus_write(2, 1, 32'd2);
    bus_write(2, 3, 32'h16);
    cap_q.delete();
    capture(2, 8);
    exp_q.delete();
    model_phase(1'b1, 3);
    model_phase(1'b0, 5);
    e = count_diff();
    n_checks++;
    if (e !== 0) $display("FAIL one_shot_wave: got %0d differing samples expected 0", e);
    else n_pass++;
    n_checks++;
    if (irq_n !== 1'b0) $display("FAIL one_shot_irq: got %0b expected 0", irq_n);
    else n_pass++;
    bus_read(2, 3, d);
    n_checks++;
    if (d !== 32'h74) $display("FAIL one_shot_ctrl: got %0h expected 74", d);
    else n_pass++;
    bus_write(2, 3, 32'h40);
    n_checks++;
    if (irq_n !== 1'b1) $display("FAIL w1c_irq_release: got %0b expected 1", irq_n);
    else n_pass++;
    bus_read(2, 3, d);
    n_checks++;
    if (d !== 32'h20) $display("FAIL w1c_ctrl: got %0h expected 20", d);
    else n_pass++;
  endtask

  task automatic test_collision();
    logic [31:0] d;
    bus_write(3, 1, 32'd1);
    bus_write(3, 2, 32'd1);
    bus_write(3, 3, 32'h02);
    // Period is 4 cycles, so the next reload lands exactly on the W1C write below.
    repeat (3) @(negedge clk);
    bus_write(3, 3, 32'h22);
    bus_read(3, 3, d);
    n_checks++;
    if (d[5] !== 1'b1) $display("FAIL flag_set_beats_clear: got %0b expected 1", d[5]);
    else n_pass++;
    bus_write(3, 3, 32'h22);
    bus_read(3, 3, d);
    n_checks++;
    if (d[5] !== 1'b0) $display("FAIL plain_w1c: got %0b expected 0", d[5]);
    else n_pass++;
    bus_write(3, 3, 32'h60);
    bus_write(3, 3, 32'h80);
    n_checks++;
    if (pwm[3] !== 1'b1) $display("FAIL invert_stopped: got %0b expected 1", pwm[3]);
    else n_pass++;
    bus_write(3, 3, 32'h00);
    n_checks++;
    if (pwm[3] !== 1'b0) $display("FAIL invert_clear: got %0b expected 0", pwm[3]);
    else n_pass++;
  endtask

  task automatic test_small_build();
    logic [31:0] d, v;
    b2_write(0, 1, 32'h1FF);
    b2_read(0, 1, d);
    n_checks++;
    if (d !== 32'hFF) $display("FAIL narrow_on: got %0h expected ff", d);
    else n_pass++;
    b2_write(3, 1, 32'h55);
    b2_read(3, 1, d);
    n_checks++;
    if (d !== 32'h0) $display("FAIL bad_channel_read: got %0h expected 0", d);
    else n_pass++;
    b2_read(0, 1, d);
    n_checks++;
    if (d !== 32'hFF) $display("FAIL bad_channel_no_alias: got %0h expected ff", d);
    else n_pass++;
    v = $urandom;
    b2_write(2, 2, v);
    b2_read(2, 2, d);
    n_checks++;
    if (d !== (v & 32'hFF)) $display("FAIL narrow_off_random: got %0h expected %0h", d, v & 32'hFF);
    else n_pass++;
    b2_write(3, 3, 32'h82);
    n_checks++;
    if ({pwm2, irq2_n} !== {3'b0, 1'b1}) $display("FAIL bad_channel_ctrl: got pwm=%0h irq_n=%0b expected 0/1", pwm2, irq2_n);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    bus.avs_s0_address  = '0; bus.avs_s0_read  = 1'b0; bus.avs_s0_write  = 1'b0; bus.avs_s0_writedata  = '0;
    bus2.avs_s0_address = '0; bus2.avs_s0_read = 1'b0; bus2.avs_s0_write = 1'b0; bus2.avs_s0_writedata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_period();
    test_stop_and_count();
    test_shadow_update();
    test_one_shot();
    test_collision();
    test_small_build();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
